// File: rtl/dcache_ctrl_if.sv
// Pipeline MEM-stage and backing-memory signals of the direct-mapped data cache.
// slave = cache controller view, master = surrounding pipeline/memory view.
interface dcache_ctrl_if;
  logic [31:0] addr_i;
  logic        memread_i;
  logic        memwrite_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  addr_i, memread_i, memwrite_i, data_i, mem_ack_i, mem_rdata_i,
    output data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output addr_i, memread_i, memwrite_i, data_i, mem_ack_i, mem_rdata_i,
    input  data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, one-word-per-line data cache controller.
// Define DCACHE_WRITE_ALLOC_EN to install lines on write misses (default: no-write-allocate).
module dcache_ctrl #(
  parameter int unsigned LINES = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dcache_ctrl_if.slave  bus
);
  localparam int unsigned INDEX_W = $clog2(LINES);
  localparam int unsigned TAG_W   = 30 - INDEX_W;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, WR_DONE} state_t;

  state_t               state_q, state_d;
  logic [LINES-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [31:0]          line_q [LINES];

  logic                 mem_req_q, mem_we_q;
  logic [31:0]          mem_addr_q, mem_wdata_q;

  logic [INDEX_W-1:0]   req_idx, ack_idx;
  logic [TAG_W-1:0]     req_tag, ack_tag;
  logic                 req_hit, ack_hit;
  logic                 stall, issue_rd, issue_wr, rd_ack, wr_ack;
  logic [31:0]          rdata;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^bus.addr_i[1:0];

  // Lookup uses the live MEM-stage address; line updates at ack use the latched request.
  assign req_idx = bus.addr_i[INDEX_W+1:2];
  assign req_tag = bus.addr_i[31:INDEX_W+2];
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign ack_idx = mem_addr_q[INDEX_W+1:2];
  assign ack_tag = mem_addr_q[31:INDEX_W+2];
  assign ack_hit = valid_q[ack_idx] && (tag_q[ack_idx] == ack_tag);

  assign rd_ack = (state_q == RD_WAIT) && bus.mem_ack_i;
  assign wr_ack = (state_q == WR_WAIT) && bus.mem_ack_i;

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    rdata    = '0;
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.memwrite_i) begin
          stall    = 1'b1;
          issue_wr = 1'b1;
          state_d  = WR_WAIT;
        end else if (bus.memread_i) begin
          if (req_hit) begin
            rdata = line_q[req_idx];
          end else begin
            stall    = 1'b1;
            issue_rd = 1'b1;
            state_d  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (bus.mem_ack_i) state_d = IDLE;
      end
      WR_WAIT: begin
        stall = 1'b1;
        if (bus.mem_ack_i) state_d = WR_DONE;
      end
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Combinational outputs are forced low while reset is held, whatever the inputs.
  assign bus.stall_o     = stall & rst_i;
  assign bus.data_o      = rdata & {32{rst_i}};
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (issue_rd) begin
        mem_req_q  <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= {bus.addr_i[31:2], 2'b00};
      end
      if (issue_wr) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= {bus.addr_i[31:2], 2'b00};
        mem_wdata_q <= bus.data_i;
      end
      if (rd_ack || wr_ack) mem_req_q <= 1'b0;
      if (rd_ack) valid_q[ack_idx] <= 1'b1;
`ifdef DCACHE_WRITE_ALLOC_EN
      if (wr_ack) valid_q[ack_idx] <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_ack) begin
      line_q[ack_idx] <= bus.mem_rdata_i;
      tag_q[ack_idx]  <= ack_tag;
    end
`ifdef DCACHE_WRITE_ALLOC_EN
    else if (wr_ack) begin
      line_q[ack_idx] <= mem_wdata_q;
      tag_q[ack_idx]  <= ack_tag;
    end
`else
    else if (wr_ack && ack_hit) begin
      line_q[ack_idx] <= mem_wdata_q;
    end
`endif
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios then randomized traffic
// against a word-addressed reference cache and backing memory.
module tb_dcache_ctrl;
  localparam int unsigned LINES   = 16;
  localparam int unsigned INDEX_W = $clog2(LINES);

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  dcache_ctrl_if bus();
  dcache_ctrl #(.LINES(LINES)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  typedef struct {
    bit          valid;
    logic [31:0] waddr;
    logic [31:0] data;
  } line_t;

  line_t       model_line [LINES];
  logic [31:0] mem_model [logic [31:0]];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_value(input logic [31:0] waddr);
    if (!mem_model.exists(waddr)) mem_model[waddr] = {waddr[15:0], ~waddr[15:0]} ^ 32'h5A5A_0000;
    return mem_model[waddr];
  endfunction

  function automatic int unsigned line_of(input logic [31:0] waddr);
    return (waddr / 4) % LINES;
  endfunction

  task automatic idle_inputs();
    bus.addr_i     = '0;
    bus.memread_i  = 1'b0;
    bus.memwrite_i = 1'b0;
    bus.data_i     = '0;
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge with inputs idle.
  task automatic access(input logic [31:0] addr, input bit rd, input bit wr,
                        input logic [31:0] wd, input int unsigned lat,
                        output int unsigned stalls);
    logic [31:0]  waddr;
    int unsigned  li;
    bit           exp_hit;
    logic [31:0]  rd_val;
    waddr  = addr & ~32'h3;
    li     = line_of(waddr);
    stalls = 0;
    bus.addr_i = addr; bus.memread_i = rd; bus.memwrite_i = wr; bus.data_i = wd;
    exp_hit = rd && !wr && model_line[li].valid && (model_line[li].waddr == waddr);
    @(negedge clk_i);
    if (!rd && !wr) begin
      chk("idle_stall", bus.stall_o, 0);
      chk("idle_data", bus.data_o, 0);
      chk("idle_req", bus.mem_req_o, 0);
      @(posedge clk_i); #1;
      idle_inputs();
      return;
    end
    if (exp_hit) begin
      chk("hit_stall", bus.stall_o, 0);
      chk("hit_data", bus.data_o, model_line[li].data);
      chk("hit_req", bus.mem_req_o, 0);
      @(posedge clk_i); #1;
      idle_inputs();
      return;
    end
    chk("miss_stall", bus.stall_o, 1);
    chk("miss_data", bus.data_o, 0);
    stalls = 1;
    rd_val = mem_value(waddr);
    @(posedge clk_i); #1;
    for (int unsigned c = 1; c <= lat; c++) begin
      if (c == lat) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = wr ? $urandom : rd_val;
      end
      @(negedge clk_i);
      chk("wait_stall", bus.stall_o, 1);
      chk("wait_req", bus.mem_req_o, 1);
      chk("wait_we", bus.mem_we_o, wr);
      chk("wait_addr", bus.mem_addr_o, waddr);
      if (wr) chk("wait_wdata", bus.mem_wdata_o, wd);
      stalls++;
      @(posedge clk_i); #1;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = $urandom;
    end
    if (wr) begin
      mem_model[waddr] = wd;
      if (model_line[li].valid && model_line[li].waddr == waddr) begin
        model_line[li].data = wd;
      end else begin
`ifdef DCACHE_WRITE_ALLOC_EN
        model_line[li] = '{valid: 1'b1, waddr: waddr, data: wd};
`endif
      end
      @(negedge clk_i);
      chk("wrdone_stall", bus.stall_o, 0);
      chk("wrdone_req", bus.mem_req_o, 0);
      chk("wrdone_data", bus.data_o, 0);
      @(posedge clk_i); #1;
      idle_inputs();
      @(negedge clk_i);
      chk("after_wr_stall", bus.stall_o, 0);
      @(posedge clk_i); #1;
    end else begin
      model_line[li] = '{valid: 1'b1, waddr: waddr, data: rd_val};
      @(negedge clk_i);
      chk("refill_stall", bus.stall_o, 0);
      chk("refill_data", bus.data_o, rd_val);
      chk("refill_req", bus.mem_req_o, 0);
      @(posedge clk_i); #1;
      idle_inputs();
    end
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < LINES; i++) model_line[i].valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    model_reset();
    @(posedge clk_i); #1;
    chk("rst_req", bus.mem_req_o, 0);
    chk("rst_we", bus.mem_we_o, 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_wdata", bus.mem_wdata_o, 0);
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_data", bus.data_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned st;
    logic [31:0] a;
    bit          rd, wr;
    idle_inputs();
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    model_reset();
    do_reset();

    // Read miss, ack in the fourth request cycle: five stall cycles then a hit.
    mem_model[32'h40] = 32'hDEADBEEF;
    access(32'h40, 1, 0, '0, 4, st);
    chk("t1_stall_cycles", st, 5);
    access(32'h40, 1, 0, '0, 1, st);
    chk("t2_hit_no_stall", st, 0);

    access(32'h40, 0, 1, 32'h12345678, 2, st);
    access(32'h40, 1, 0, '0, 1, st);
    chk("t3_read_after_write", st, 0);

    // Same index, different tag: write must not disturb 0x40 unless allocating.
    access(32'h440, 0, 1, 32'hCAFEF00D, 1, st);
    access(32'h40, 1, 0, '0, 2, st);
`ifdef DCACHE_WRITE_ALLOC_EN
    chk("t4_victim_miss", st != 0, 1);
`else
    chk("t4_victim_hit", st, 0);
`endif
    access(32'h440, 1, 0, '0, 3, st);

    // Reset while a read miss is outstanding; a late ack must be ignored.
    do_reset();
    bus.addr_i = 32'h40; bus.memread_i = 1'b1;
    @(negedge clk_i);
    chk("t5_pre_stall", bus.stall_o, 1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("t5_req_up", bus.mem_req_o, 1);
    rst_i = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_req", bus.mem_req_o, 0);
    chk("t5_rst_stall", bus.stall_o, 0);
    @(posedge clk_i); #1;
    idle_inputs();
    rst_i = 1'b1;
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hBAD0BAD0;
    @(negedge clk_i);
    chk("t5_late_ack_req", bus.mem_req_o, 0);
    chk("t5_late_ack_stall", bus.stall_o, 0);
    @(posedge clk_i); #1;
    bus.mem_ack_i = 1'b0;
    access(32'h40, 1, 0, '0, 2, st);
    chk("t5_refetch_miss", st, 3);

    // Read and write together behave as a write.
    access(32'h80, 1, 1, 32'h0BADF00D, 1, st);
    access(32'h80, 1, 0, '0, 1, st);

    for (int n = 0; n < 400; n++) begin
      a  = ($urandom_range(3, 0) << (INDEX_W + 2)) | ($urandom_range(LINES - 1, 0) << 2)
           | $urandom_range(3, 0);
      rd = $urandom_range(1, 0) == 1;
      wr = $urandom_range(3, 0) == 0;
      if (!rd && !wr && $urandom_range(1, 0) == 1) begin
        bus.mem_ack_i = 1'b1; bus.mem_rdata_i = $urandom;
      end
      access(a, rd, wr, $urandom, $urandom_range(4, 1), st);
      bus.mem_ack_i = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through data cache controller between the pipeline's MEM stage and a slow backing memory with a req/ack handshake.
- Consumes the MEM-stage address, read/write controls and store data. Returns load data and a stall_o that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB while a memory transaction is outstanding.
- One 32-bit word per line. Read miss allocates; write hit updates the line.

Parameters:
- LINES, 16, number of cache lines; power of two, minimum 2.
- INDEX_W, $clog2(LINES), index width; derived, not overridden.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-low.
- addr_i  input  32  MEM-stage byte address; bits [1:0] ignored.
- memread_i  input  1  load request.
- memwrite_i  input  1  store request; wins over memread_i if both set.
- data_i  input  32  store data.
- data_o  output  32  load data; 0 when not a read hit.
- stall_o  output  1  pipeline freeze request.
- mem_req_o  output  1  backing-memory request, registered.
- mem_we_o  output  1  1 = write, 0 = read, registered.
- mem_addr_o  output  32  word-aligned address ({addr_i[31:2],2'b00}), registered.
- mem_wdata_o  output  32  store data, registered.
- mem_ack_i  input  1  one-cycle completion pulse; carries read data.
- mem_rdata_i  input  32  read data, valid with mem_ack_i.

Behaviour:
- Address split:
  - index = addr_i[INDEX_W+1:2].
  - tag = addr_i[31:INDEX_W+2].
  - hit = valid[index] and tag match.
- Reset (rst_i low, asynchronous):
  - All valid bits cleared; state = IDLE.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - stall_o = 0, data_o = 0.
  - Reset mid-transaction abandons it. A later mem_ack_i arriving in IDLE is ignored.
- States: IDLE, RD_WAIT, WR_WAIT, WR_DONE.
- IDLE, no request: stall_o = 0; no transition.
- IDLE, read hit:
  - data_o = line data combinationally, same cycle.
  - stall_o = 0; stays in IDLE. Zero-cycle penalty.
- IDLE, read miss:
  - stall_o = 1 combinationally.
  - Next edge: mem_req_o = 1, mem_we_o = 0, address latched; go to RD_WAIT.
- IDLE, write (hit or miss):
  - stall_o = 1.
  - Next edge: mem_req_o = 1, mem_we_o = 1, address and data latched; go to WR_WAIT.
- RD_WAIT:
  - stall_o = 1; request outputs held stable until mem_ack_i.
  - On ack: write mem_rdata_i to the line, set valid and tag, drop mem_req_o, return to IDLE.
  - The held request then hits in IDLE. Minimum read-miss penalty = 2 + memory latency cycles.
- WR_WAIT:
  - stall_o = 1; request outputs held stable until mem_ack_i.
  - On ack: if the line hits, update its data; drop mem_req_o; go to WR_DONE.
  - Write miss does not allocate (see Optional Feature).
- WR_DONE:
  - stall_o = 0 for exactly one cycle so the pipeline advances past the store.
  - Inputs are ignored, so the write is never reissued.
  - Next state IDLE.
- mem_ack_i outside RD_WAIT/WR_WAIT is ignored.
- mem_ack_i asserted in the first wait cycle is legal.
- Store to the same word as a following load: the load sees the new data (line updated at ack, or line invalid/old-tag miss refetches).
- A write miss to a valid line with a different tag leaves that line untouched.

Optional Feature:
- Macro: DCACHE_WRITE_ALLOC_EN.
- Defined: on a write miss, at mem_ack_i in WR_WAIT the line is installed (data = stored word, tag = write tag, valid = 1), replacing any previous occupant.
- Undefined: no-write-allocate, as in Behaviour.
- Hit reads and all stall timing are identical in both builds.

Test Plan:
1. Reset, then memread_i=1, addr 0x40; memory acks with 0xDEADBEEF 3 cycles after req:
   - stall_o high 5 cycles; mem_addr_o = 0x40, mem_we_o = 0.
   - Next cycle: hit, data_o = 0xDEADBEEF, stall_o = 0.
2. Read 0x40 again immediately: stall_o = 0, data_o = 0xDEADBEEF, mem_req_o stays 0.
3. Write 0x12345678 to 0x40, ack after 1 cycle:
   - mem_we_o = 1, mem_wdata_o = 0x12345678.
   - One WR_DONE cycle with stall_o = 0.
   - Then read 0x40 hits with 0x12345678.
4. LINES=16: read 0x40 (cached); write 0x440 (same index, other tag):
   - Without macro: read 0x40 still hits.
   - With DCACHE_WRITE_ALLOC_EN: read 0x40 misses and read 0x440 hits with the written data.
5. Read miss in flight, pulse rst_i low for 1 cycle before ack:
   - mem_req_o = 0, stall_o = 0 immediately.
   - Late ack ignored; read 0x40 misses again.
6. memread_i=1 and memwrite_i=1 together at 0x80: treated as a write (mem_we_o = 1), no read refill issued.
